seq_accum_ctrl: RTL and testbench

- Parametrised memory-scan accumulation controller.
- Reads `NUM_SETS` sets of `SET_LEN` words from a single-port synchronous memory and reduces each set with an internal accumulator.
- Writes each per-set result back to the word after the set, then reduces the per-set results into a grand total written at `TOTAL_ADDR`.
- Next generation of the fixed 5×4 summing controller. Adds a start/done handshake, a sum/max mode, an integrated accumulator with sticky overflow, and generic geometry.

---
 rtl/seq_accum_pkg.sv | 18 +
 rtl/accum_unit.sv | 43 ++++
 rtl/seq_accum_ctrl.sv | 147 ++++++++++++++
 tb/tb_seq_accum_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_accum_pkg.sv
// Shared types for the memory-scan accumulation controller.
package seq_accum_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ELEM,
        ACC_ELEM,
        WR_SET,
        RD_PART,
        ACC_PART,
        WR_TOTAL,
        DONE
    } state_e;

    localparam logic MODE_SUM = 1'b0;
    localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/accum_unit.sv
// Accumulator register: clear, enable, unsigned sum or max, carry-out on sum.
module accum_unit
    import seq_accum_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] acc_o,
    output logic              carry_o
);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W:0]   sum;

    assign sum   = {1'b0, acc_q} + {1'b0, data_i};
    assign acc_o = acc_q;

    always_comb begin
        acc_d   = acc_q;
        carry_o = 1'b0;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            if (mode_i == MODE_MAX) begin
                if (data_i > acc_q) acc_d = data_i;
            end else begin
                acc_d   = sum[DATA_W-1:0];
                carry_o = sum[DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

endmodule

// File: rtl/seq_accum_ctrl.sv
// Scans NUM_SETS sets of SET_LEN words, writes per-set results after each
// set, then reduces those results into a grand total at TOTAL_ADDR.
module seq_accum_ctrl
    import seq_accum_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 5,
    parameter int NUM_SETS   = 5,
    parameter int SET_LEN    = 4,
    parameter int TOTAL_ADDR = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(SET_LEN + 1);
    localparam logic [ADDR_W-1:0] RES_OFS   = ADDR_W'(SET_LEN);
    localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(SET_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_SET  = ADDR_W'(NUM_SETS - 1);
    localparam logic [ADDR_W-1:0] TOT_ADDR  = ADDR_W'(TOTAL_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] set_q, set_d, elem_q, elem_d, base;
    logic              mode_q, mode_d, ovf_q, ovf_d;
    logic              accept, acc_clr, acc_en, acc_carry;
    logic [DATA_W-1:0] acc;

    assign accept  = (state_q == IDLE) && start;
    assign acc_clr = accept || (state_q == WR_SET);
    assign acc_en  = (state_q == ACC_ELEM) || (state_q == ACC_PART);
    assign base    = set_q * STRIDE;

    accum_unit #(.DATA_W(DATA_W)) u_acc (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (acc_clr),
        .en_i    (acc_en),
        .mode_i  (mode_q),
        .data_i  (mem_rdata),
        .acc_o   (acc),
        .carry_o (acc_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = RD_ELEM;
            RD_ELEM:  state_d = ACC_ELEM;
            ACC_ELEM: state_d = (elem_q == LAST_ELEM) ? WR_SET : RD_ELEM;
            WR_SET:   state_d = (set_q == LAST_SET) ? RD_PART : RD_ELEM;
            RD_PART:  state_d = ACC_PART;
            ACC_PART: state_d = (set_q == LAST_SET) ? WR_TOTAL : RD_PART;
            WR_TOTAL: state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Strobes are masked during reset so an aborted run cannot commit a write.
    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (!reset) begin
            unique case (state_q)
                RD_ELEM: begin
                    mem_addr = base + elem_q;
                    mem_re   = 1'b1;
                end
                WR_SET: begin
                    mem_addr  = base + RES_OFS;
                    mem_we    = 1'b1;
                    mem_wdata = acc;
                end
                RD_PART: begin
                    mem_addr = base + RES_OFS;
                    mem_re   = 1'b1;
                end
                WR_TOTAL: begin
                    mem_addr  = TOT_ADDR;
                    mem_we    = 1'b1;
                    mem_wdata = acc;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign overflow = ovf_q;

    always_comb begin
        set_d  = set_q;
        elem_d = elem_q;
        mode_d = mode_q;
        ovf_d  = ovf_q | acc_carry;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    set_d  = '0;
                    elem_d = '0;
                    mode_d = mode;
                    ovf_d  = 1'b0;
                end
            end
            ACC_ELEM: if (elem_q != LAST_ELEM) elem_d = elem_q + 1'b1;
            WR_SET: begin
                elem_d = '0;
                set_d  = (set_q == LAST_SET) ? '0 : set_q + 1'b1;
            end
            ACC_PART: if (set_q != LAST_SET) set_d = set_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            set_q  <= '0;
            elem_q <= '0;
            mode_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            set_q  <= set_d;
            elem_q <= elem_d;
            mode_q <= mode_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_seq_accum_ctrl.sv
// Scoreboard bench: expected writes queued at start, popped on each mem_we.
module tb_seq_accum_ctrl;

    localparam int LAT0 = 5 * (2 * 4 + 1) + 2 * 5 + 2;
    localparam int LAT1 = 2 * (2 * 1 + 1) + 2 * 2 + 2;

    logic        clk = 1'b0;
    logic        reset, start, mode, start1, mode1, load0, load1;
    logic [15:0] rdata0, rdata1, wdata0, wdata1;
    logic [4:0]  addr0, addr1;
    logic        re0, we0, busy0, done0, ovf0;
    logic        re1, we1, busy1, done1, ovf1;

    logic [15:0] mem0 [32];
    logic [15:0] img0 [32];
    logic [15:0] mem1 [32];
    logic [15:0] img1 [32];

    int exp0_a[$], exp0_d[$], exp1_a[$], exp1_d[$];
    int n_vec = 0, n_err = 0;
    int ea0, ed0, ea1, ed1, n;
    bit exp_ovf0;

    always #5 clk = ~clk;

    seq_accum_ctrl u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .mem_rdata(rdata0), .mem_addr(addr0), .mem_re(re0),
        .mem_we(we0), .mem_wdata(wdata0), .busy(busy0),
        .done(done0), .overflow(ovf0)
    );

    seq_accum_ctrl #(
        .DATA_W(16), .ADDR_W(5), .NUM_SETS(2), .SET_LEN(1), .TOTAL_ADDR(7)
    ) u_geo (
        .clk(clk), .reset(reset), .start(start1), .mode(mode1),
        .mem_rdata(rdata1), .mem_addr(addr1), .mem_re(re1),
        .mem_we(we1), .mem_wdata(wdata1), .busy(busy1),
        .done(done1), .overflow(ovf1)
    );

    always @(posedge clk) begin
        if (load0) mem0 <= img0;
        else if (we0) mem0[addr0] <= wdata0;
        if (re0) rdata0 <= mem0[addr0];
        if (load1) mem1 <= img1;
        else if (we1) mem1[addr1] <= wdata1;
        if (re1) rdata1 <= mem1[addr1];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (re0 || we0) check("re_we_excl0", 32'(re0 & we0), 32'd0);
        if (we0) begin
            if (exp0_a.size() == 0) begin
                check("wr0_unexpected", 32'(addr0), 32'hffff_ffff);
            end else begin
                ea0 = exp0_a.pop_front();
                ed0 = exp0_d.pop_front();
                check("wr0_addr", 32'(addr0), ea0);
                check("wr0_data", 32'(wdata0), ed0);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (re1 || we1) check("re_we_excl1", 32'(re1 & we1), 32'd0);
        if (we1) begin
            if (exp1_a.size() == 0) begin
                check("wr1_unexpected", 32'(addr1), 32'hffff_ffff);
            end else begin
                ea1 = exp1_a.pop_front();
                ed1 = exp1_d.pop_front();
                check("wr1_addr", 32'(addr1), ea1);
                check("wr1_data", 32'(wdata1), ed1);
            end
        end
    end

    function automatic logic [15:0] red(input logic m, input logic [15:0] a,
                                        input logic [15:0] d);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, d};
        if (m) return (d > a) ? d : a;
        return s[15:0];
    endfunction

    // Behavioural reduction of img0 into the expected write stream.
    task automatic push_exp0(input logic m, input int nw);
        logic [15:0] acc, d;
        logic [15:0] part [5];
        int w = 0;
        exp_ovf0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            acc = '0;
            for (int e = 0; e < 4; e++) begin
                d = img0[k*5+e];
                if (!m && (32'(acc) + 32'(d) > 32'hffff)) exp_ovf0 = 1'b1;
                acc = red(m, acc, d);
            end
            part[k] = acc;
            if (w < nw) begin
                exp0_a.push_back(k * 5 + 4);
                exp0_d.push_back(int'(acc));
                w++;
            end
        end
        acc = '0;
        for (int k = 0; k < 5; k++) begin
            if (!m && (32'(acc) + 32'(part[k]) > 32'hffff)) exp_ovf0 = 1'b1;
            acc = red(m, acc, part[k]);
        end
        if (w < nw) begin
            exp0_a.push_back(31);
            exp0_d.push_back(int'(acc));
        end
    endtask

    task automatic load_img0();
        load0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load0 = 1'b0;
    endtask

    task automatic run0(input logic m, input bit hold, input int poke,
                        input int rst_at, output int cnt);
        start = 1'b1;
        mode  = m;
        cnt   = 0;
        while (cnt < 300) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            start = hold || (cnt == poke);
            if (cnt == 1) begin
                check("first_re", 32'(re0), 32'd1);
                check("busy_run", 32'(busy0), 32'd1);
                check("ovf_clr", 32'(ovf0), 32'd0);
            end
            if (cnt == LAT0 - 1) check("busy_wrt", 32'(busy0), 32'd1);
            if (cnt == rst_at) begin
                reset = 1'b1;
                start = 1'b1;
                #1;
                check("rst_we_mask", 32'(we0), 32'd0);
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                start = 1'b0;
                check("rst_busy", 32'(busy0), 32'd0);
                check("rst_re", 32'(re0), 32'd0);
                check("rst_addr", 32'(addr0), 32'd0);
                check("rst_done", 32'(done0), 32'd0);
                @(posedge clk);
                @(negedge clk);
                check("rst_start_ign", 32'(busy0), 32'd0);
                return;
            end
            if (done0) break;
        end
        check("done_seen", 32'(done0), 32'd1);
    endtask

    task automatic basic_img();
        for (int i = 0; i < 32; i++) img0[i] = '0;
        for (int i = 0; i < 20; i++) img0[(i / 4) * 5 + (i % 4)] = 16'(i + 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        start1 = 1'b0; mode1 = 1'b0; load0 = 1'b0; load1 = 1'b0;
        basic_img();
        for (int i = 0; i < 32; i++) img1[i] = '0;
        img1[0] = 16'd3;
        img1[2] = 16'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_re", 32'(re0), 32'd0);
        check("reset_we", 32'(we0), 32'd0);
        check("reset_addr", 32'(addr0), 32'd0);
        check("reset_wdata", 32'(wdata0), 32'd0);
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_done", 32'(done0), 32'd0);
        check("reset_ovf", 32'(ovf0), 32'd0);
        check("reset_busy1", 32'(busy1), 32'd0);
        reset = 1'b0;
        load1 = 1'b1;
        load_img0();
        load1 = 1'b0;

        push_exp0(1'b0, 6);
        run0(1'b0, 1'b0, 0, 0, n);
        check("sum_latency", n, LAT0);
        check("sum_ovf", 32'(ovf0), 32'(exp_ovf0));
        check("sum_total_mem", 32'(mem0[31]), 32'd210);
        @(posedge clk);
        @(negedge clk);
        check("done_pulse", 32'(done0), 32'd0);
        check("sum_q_empty", 32'(exp0_a.size()), 32'd0);

        push_exp0(1'b1, 6);
        run0(1'b1, 1'b0, 0, 0, n);
        check("max_latency", n, LAT0);
        check("max_total_mem", 32'(mem0[31]), 32'd20);
        check("max_ovf", 32'(ovf0), 32'd0);

        for (int i = 0; i < 20; i++) img0[(i / 4) * 5 + (i % 4)] = 16'h8000;
        load_img0();
        push_exp0(1'b0, 6);
        run0(1'b0, 1'b0, 0, 0, n);
        check("ovf_latency", n, LAT0);
        check("ovf_set", 32'(ovf0), 32'(exp_ovf0));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("ovf_sticky", 32'(ovf0), 32'd1);

        push_exp0(1'b0, 6);
        run0(1'b0, 1'b0, 20, 0, n);
        check("poke_latency", n, LAT0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("poke_idle", 32'(busy0), 32'd0);
        check("poke_q_empty", 32'(exp0_a.size()), 32'd0);

        basic_img();
        load_img0();
        push_exp0(1'b0, 6);
        run0(1'b0, 1'b1, 0, 0, n);
        check("hold1_latency", n, LAT0);
        push_exp0(1'b0, 6);
        @(posedge clk);
        @(negedge clk);
        check("hold_idle_busy", 32'(busy0), 32'd0);
        check("hold_idle_done", 32'(done0), 32'd0);
        run0(1'b0, 1'b0, 0, 0, n);
        check("hold2_latency", n, LAT0);

        basic_img();
        img0[14] = 16'hdead;
        img0[31] = 16'hdead;
        load_img0();
        push_exp0(1'b0, 2);
        run0(1'b0, 1'b0, 0, 27, n);
        check("abort_q_empty", 32'(exp0_a.size()), 32'd0);
        check("abort_mem14", 32'(mem0[14]), 32'hdead);
        check("abort_mem31", 32'(mem0[31]), 32'hdead);
        push_exp0(1'b0, 6);
        run0(1'b0, 1'b0, 0, 0, n);
        check("rerun_latency", n, LAT0);
        check("rerun_total", 32'(mem0[31]), 32'd210);

        exp1_a.push_back(1); exp1_d.push_back(3);
        exp1_a.push_back(3); exp1_d.push_back(5);
        exp1_a.push_back(7); exp1_d.push_back(8);
        start1 = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start1 = 1'b0;
            if (done1) break;
        end
        check("geo_done", 32'(done1), 32'd1);
        check("geo_latency", n, LAT1);
        check("geo_total_mem", 32'(mem1[7]), 32'd8);
        @(posedge clk);
        @(negedge clk);
        check("geo_q_empty", 32'(exp1_a.size()), 32'd0);
        check("final_q_empty", 32'(exp0_a.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
